// File: rtl/rd_fifo_ctrl_pkg.sv
// rd_fifo_ctrl_pkg: shared definitions for the read-FIFO fill controller.
//   state_e    - controller state encoding
//   BEAT_BYTES - bytes carried by one 128-bit read beat
package rd_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_FIFO,
    CHECK,
    REQ,
    DRAIN
  } state_e;

  localparam int unsigned BEAT_BYTES = 16;

endpackage

// File: rtl/rd_fifo_fill_ctrl.sv
// rd_fifo_fill_ctrl: issues burst read commands that fill a FIFO with one
// frame of 128-bit beats, never requesting more data than the FIFO can hold.
//
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   frame_start                - one-cycle frame request (restarts if busy)
//   cmd_valid/cmd_ready        - read command handshake
//   cmd_addr, cmd_len          - burst byte address, beats minus one
//   beat_valid                 - read data beat arriving
//   fifo_wr_en                 - FIFO write enable (mirrors beat_valid)
//   fifo_wr_water_level        - FIFO write-side fill level
//   fifo_wr_full               - FIFO full flag
//   fifo_rst                   - active-high FIFO reset
//   busy, frame_done           - frame in progress, completion pulse
//   err_overflow               - sticky overflow flag (RD_FIFO_FILL_CTRL_ERR_EN only)
//
// Optional feature: define RD_FIFO_FILL_CTRL_ERR_EN to add err_overflow.
module rd_fifo_fill_ctrl
  import rd_fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DEPTH_W     = 10,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_BEATS = 230400,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RST_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              beat_valid,
  output logic              fifo_wr_en,
  input  logic [DEPTH_W:0]  fifo_wr_water_level,
  input  logic              fifo_wr_full,
  output logic              fifo_rst,
  output logic              busy,
`ifdef RD_FIFO_FILL_CTRL_ERR_EN
  output logic              err_overflow,
`endif
  output logic              frame_done
);

  localparam int unsigned REM_W = $clog2(FRAME_BEATS + 1);
  localparam int unsigned LEN_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned OUT_W = DEPTH_W + 1;
  localparam int unsigned SUM_W = DEPTH_W + LEN_W + 2;
  localparam int unsigned CAP   = 2 ** DEPTH_W;

  state_e             r_state;
  state_e             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [REM_W-1:0]   r_remaining;
  logic [OUT_W-1:0]   r_outstanding;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_rst_cnt;
  logic               r_pending;

  logic [LEN_W-1:0]   w_len;
  logic [SUM_W-1:0]   w_need;
  logic               w_fits;
  logic               w_hs;
  logic               w_pend;
  logic               w_load;
  logic               w_take;
  logic               w_frame_done;
  logic [REM_W-1:0]   w_rem_after;
  logic               w_dec;

  always_comb begin
    w_len = LEN_W'(r_remaining);
    if (32'(r_remaining) >= BURST_LEN) w_len = LEN_W'(BURST_LEN);
  end

  // Space check counts beats already in the FIFO plus beats still in flight.
  assign w_need      = SUM_W'(fifo_wr_water_level) + SUM_W'(r_outstanding) + SUM_W'(w_len);
  assign w_fits      = (w_need <= SUM_W'(CAP));
  assign w_hs        = (r_state == REQ) && cmd_ready;
  // A frame_start arriving this cycle counts as pending immediately so no
  // further command can slip out on the same edge.
  assign w_pend      = r_pending | frame_start;
  assign w_rem_after = r_remaining - REM_W'(r_len);
  // A beat decrements outstanding; a stray beat with nothing in flight is
  // ignored unless a burst is accepted on the same edge.
  assign w_dec       = beat_valid && ((r_outstanding != '0) || w_hs);

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_take       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_next = RST_FIFO;
          w_load = 1'b1;
        end
      end
      RST_FIFO: begin
        if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) w_next = CHECK;
      end
      CHECK: begin
        if (w_pend || (r_remaining == '0)) begin
          w_next = DRAIN;
        end else if (w_fits) begin
          w_next = REQ;
          w_take = 1'b1;
        end
      end
      REQ: begin
        if (cmd_ready) begin
          if ((w_rem_after == '0) || w_pend) w_next = DRAIN;
          else                               w_next = CHECK;
        end
      end
      DRAIN: begin
        if (r_outstanding == '0) begin
          if (w_pend) begin
            w_next = RST_FIFO;
            w_load = 1'b1;
          end else begin
            w_next       = IDLE;
            w_frame_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_len         <= '0;
      r_rst_cnt     <= '0;
      r_pending     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_outstanding <= r_outstanding + (w_hs ? OUT_W'(r_len) : '0) - (w_dec ? OUT_W'(1) : '0);
      if (w_load) begin
        r_addr      <= ADDR_W'(BASE_ADDR);
        r_remaining <= REM_W'(FRAME_BEATS);
        r_rst_cnt   <= '0;
        r_pending   <= 1'b0;
      end else begin
        if (frame_start && (r_state != IDLE)) r_pending <= 1'b1;
        if (r_state == RST_FIFO) r_rst_cnt <= r_rst_cnt + CNT_W'(1);
        if (w_take) r_len <= w_len;
        if (w_hs) begin
          r_remaining <= w_rem_after;
          r_addr      <= r_addr + ADDR_W'(32'(r_len) * BEAT_BYTES);
        end
      end
    end
  end

`ifdef RD_FIFO_FILL_CTRL_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n)                                                    r_err <= 1'b0;
    else if (beat_valid && (fifo_wr_full || (r_outstanding == '0))) r_err <= 1'b1;
  end
  assign err_overflow = r_err;
`else
  logic w_unused_full;
  assign w_unused_full = fifo_wr_full;
`endif

  assign cmd_valid  = (r_state == REQ);
  assign cmd_addr   = r_addr;
  assign cmd_len    = (r_state == REQ) ? 8'(r_len - LEN_W'(1)) : '0;
  assign fifo_wr_en = beat_valid;
  assign fifo_rst   = (r_state == RST_FIFO);
  assign busy       = (r_state != IDLE);
  assign frame_done = w_frame_done;

endmodule

// File: doc/rd_fifo_fill_ctrl.md
RD_FIFO_FILL_CTRL -- requirements
Module: rd_fifo_fill_ctrl

Interface
REQ-001 Parameters SHALL be one per line:
- ADDR_W, 28, memory byte-address width.
- DEPTH_W, 10, FIFO write-side depth width; capacity is 2^DEPTH_W beats of 128 bits.
- BURST_LEN, 16, maximum beats per read command.
- FRAME_BEATS, 230400, 128-bit beats per frame.
- BASE_ADDR, 0, frame start byte address.
- RST_CYCLES, 8, FIFO reset hold length.
REQ-002 The block SHALL have one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 Ports SHALL be one per line:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle frame request.
- cmd_valid  out  1  read command valid.
- cmd_ready  in  1  memory accepts command.
- cmd_addr  out  ADDR_W  burst byte address.
- cmd_len  out  8  beats minus one.
- beat_valid  in  1  read data beat arriving.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_water_level  in  DEPTH_W+1  FIFO write-side fill.
- fifo_wr_full  in  1  FIFO full.
- fifo_rst  out  1  active-high FIFO reset.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle frame completion.

Function
REQ-004 The state machine SHALL have the states IDLE, RST_FIFO, CHECK, REQ and DRAIN.
REQ-005 In IDLE, frame_start SHALL move the block to RST_FIFO, load addr=BASE_ADDR and set remaining=FRAME_BEATS.
REQ-006 RST_FIFO SHALL assert fifo_rst for exactly RST_CYCLES cycles, then move to CHECK.
REQ-007 CHECK SHALL move to REQ when water_level+outstanding+len <= 2^DEPTH_W, where len = min(BURST_LEN, remaining); otherwise it SHALL stay in CHECK.
REQ-008 REQ SHALL hold cmd_valid high with cmd_addr and cmd_len stable until cmd_ready is sampled high.
REQ-009 On REQ handshake, the block SHALL add len to outstanding, subtract len from remaining, and add len*16 to addr modulo 2^ADDR_W.
REQ-010 After the REQ handshake, the block SHALL go to DRAIN if remaining==0, else to CHECK.
REQ-011 DRAIN SHALL wait for outstanding==0, then pulse frame_done for one cycle and return to IDLE.
REQ-012 fifo_wr_en SHALL equal beat_valid combinationally; every beat_valid SHALL decrement outstanding.
REQ-013 A simultaneous handshake and beat SHALL change outstanding by len-1 in one cycle.
REQ-014 outstanding SHALL be DEPTH_W+1 bits wide and SHALL never exceed 2^DEPTH_W.
REQ-015 frame_start outside IDLE SHALL be latched as pending, and no new command SHALL issue afterwards.
REQ-016 With pending set, the block SHALL go to DRAIN; at outstanding==0 it SHALL go to RST_FIFO without pulsing frame_done.
REQ-017 A final burst SHALL be shorter than BURST_LEN when remaining < BURST_LEN (e.g. cmd_len=remaining-1).
REQ-018 busy SHALL be high in every state except IDLE.

Reset
REQ-019 While rst_n=0 at a clk edge, the block SHALL enter IDLE with all outputs 0 and outstanding, remaining, addr and pending cleared.
REQ-020 Reset mid-burst SHALL abandon all outstanding beats; fifo_wr_en still follows beat_valid.

Configuration
REQ-021 With macro RD_FIFO_FILL_CTRL_ERR_EN defined, the block SHALL add an output err_overflow (1 bit).
REQ-022 err_overflow SHALL set on beat_valid&fifo_wr_full, or on beat_valid with outstanding==0, and clear only on reset.
REQ-023 Without the macro, the port and its logic SHALL be absent, with no other behavioural difference.

Structure
REQ-024 The state enum and beat byte size (16) SHALL live in the shared package rd_fifo_ctrl_pkg.
REQ-025 The block SHALL be a single module with no sub-modules.

Verification
REQ-026 Reset, then frame_start with cmd_ready tied 1, beats returned 4 cycles after each command, FRAME_BEATS=64 -> 4 commands at addr 0, 256, 512, 768, cmd_len=15, then one frame_done.
REQ-027 FRAME_BEATS=40 -> cmd_len sequence 15, 15, 7.
REQ-028 water_level held at 1010 -> no cmd_valid; lowering it to 1008 -> cmd_valid within 2 cycles.
REQ-029 cmd_ready held low for 10 cycles -> cmd_addr and cmd_len stable, outstanding unchanged.
REQ-030 frame_start mid-frame with 16 beats outstanding -> no new command, 16 beats written, fifo_rst high for 8 cycles, restart at BASE_ADDR, no frame_done.
REQ-031 rst_n low for 1 cycle mid-burst -> IDLE, all outputs 0; with ERR_EN, a stray beat afterwards -> err_overflow=1.
